// File: rtl/idecode_pipe_if.sv
// ID-stage bus: fetch input, write-back port, flush and the registered ID/EX output.
// The slave side is the decode stage; the master side is its environment.
interface idecode_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc_plus4;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [DATA_W-1:0] out_imm;
  logic [REG_AW-1:0] out_dst;
  logic [DATA_W-1:0] out_pc_plus4;
  logic [31:0]       out_instr;

  modport master (
    output in_valid, instruction, pc_plus4, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_dst, out_pc_plus4, out_instr
  );

  modport slave (
    input  in_valid, instruction, pc_plus4, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_dst, out_pc_plus4, out_instr
  );
endinterface

// File: rtl/idecode_pipe.sv
// Pipelined decode: regfile with WB bypass, dst select, imm extend, ID/EX register; 1-cycle latency.
// in_ready drops on output back-pressure or a load-use hazard (one bubble); flush kills stage and input.
module idecode_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input logic           clock,
  input logic           reset,
  idecode_pipe_if.slave bus
);
  localparam int NREG = 1 << REG_AW;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;

  logic [DATA_W-1:0] regs [NREG];

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm_ext;
  logic [REG_AW-1:0] dst;
  logic              wb_write;
  logic              hazard;
  logic              accept;

  assign opcode   = bus.instruction[31:26];
  assign rs       = REG_AW'(bus.instruction[25:21]);
  assign rt       = REG_AW'(bus.instruction[20:16]);
  assign rd       = REG_AW'(bus.instruction[15:11]);
  assign imm      = bus.instruction[15:0];
  assign wb_write = bus.wb_en && (bus.wb_addr != '0);

  // Entry 0 is never written; reads of r0 are forced to zero below.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Write-before-read: a same-cycle write-back to the read register wins.
  always_comb begin
    rs_data = regs[rs];
    if (rs == '0)                          rs_data = '0;
    else if (wb_write && bus.wb_addr == rs) rs_data = bus.wb_data;

    rt_data = regs[rt];
    if (rt == '0)                          rt_data = '0;
    else if (wb_write && bus.wb_addr == rt) rt_data = bus.wb_data;
  end

  always_comb begin
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(DATA_W-16){1'b0}}, imm};
      OP_LUI:                   imm_ext = DATA_W'($signed({imm, 16'h0000}));
      default:                  imm_ext = DATA_W'($signed(imm));
    endcase
  end

  always_comb begin
    case (opcode)
      OP_RTYPE: dst = rd;
      OP_JAL:   dst = REG_AW'(LINK_REG);
      default:  dst = rt;
    endcase
  end

  // rt is compared even when the consumer does not read it, so stalls are conservative.
  assign hazard = bus.out_valid && (bus.out_instr[31:26] == OP_LW) && (bus.out_dst != '0) &&
                  ((rs == bus.out_dst) || (rt == bus.out_dst));

  assign bus.in_ready = bus.flush || ((!bus.out_valid || bus.out_ready) && !hazard);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.out_valid    <= 1'b0;
      bus.out_rs_data  <= '0;
      bus.out_rt_data  <= '0;
      bus.out_imm      <= '0;
      bus.out_dst      <= '0;
      bus.out_pc_plus4 <= '0;
      bus.out_instr    <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid    <= 1'b1;
      bus.out_rs_data  <= rs_data;
      bus.out_rt_data  <= rt_data;
      bus.out_imm      <= imm_ext;
      bus.out_dst      <= dst;
      bus.out_pc_plus4 <= bus.pc_plus4;
      bus.out_instr    <= bus.instruction;
    end else if (bus.out_ready) begin
      // Covers hazard cycles too: the load leaves and a bubble takes its place.
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_idecode_pipe.sv
// Scoreboard bench for idecode_pipe: expected decodes are queued on accept and compared on consume.
module tb_idecode_pipe;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic [31:0] pc;
    logic [31:0] instr;
  } dec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idecode_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  idecode_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LINK_REG(31)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  dec_t        sb_q[$];
  logic [31:0] ref_rf [32];

  logic        d_in_valid, d_out_ready, d_flush, d_wb_en;
  logic [31:0] d_instr, d_pc, d_wb_data;
  logic [4:0]  d_wb_addr;

  logic        o_in_ready, o_out_valid, popped, unexpected;
  dec_t        o_out, exp_out;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (d_wb_en && d_wb_addr == a) return d_wb_data;
    return ref_rf[a];
  endfunction

  function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc);
    dec_t        m;
    logic [5:0]  op;
    logic [15:0] im;
    op        = ins[31:26];
    im        = ins[15:0];
    m.rs_data = model_rd(ins[25:21]);
    m.rt_data = model_rd(ins[20:16]);
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) m.imm = {16'h0000, im};
    else if (op == 6'h0F)                          m.imm = {im, 16'h0000};
    else                                           m.imm = {{16{im[15]}}, im};
    if (op == 6'h00)      m.dst = ins[15:11];
    else if (op == 6'h03) m.dst = 5'd31;
    else                  m.dst = ins[20:16];
    m.pc    = pc;
    m.instr = ins;
    return m;
  endfunction

  task automatic idle();
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    d_flush     = 1'b0;
    d_wb_en     = 1'b0;
    d_wb_addr   = 5'd0;
    d_wb_data   = 32'h0;
    d_instr     = 32'h0;
    d_pc        = 32'h0;
  endtask

  task automatic apply();
    bus.in_valid    = d_in_valid;
    bus.instruction = d_instr;
    bus.pc_plus4    = d_pc;
    bus.wb_en       = d_wb_en;
    bus.wb_addr     = d_wb_addr;
    bus.wb_data     = d_wb_data;
    bus.flush       = d_flush;
    bus.out_ready   = d_out_ready;
  endtask

  // One cycle: drive after the falling edge, observe 1 ns later, update the scoreboard for the next rising edge.
  task automatic tick();
    @(negedge clk);
    apply();
    #1;
    o_in_ready  = bus.in_ready;
    o_out_valid = bus.out_valid;
    o_out       = {bus.out_rs_data, bus.out_rt_data, bus.out_imm, bus.out_dst, bus.out_pc_plus4, bus.out_instr};
    popped      = 1'b0;
    unexpected  = 1'b0;
    if (d_flush) begin
      sb_q.delete();
    end else begin
      if (o_out_valid && d_out_ready) begin
        if (sb_q.size() == 0) unexpected = 1'b1;
        else begin
          exp_out = sb_q.pop_front();
          popped  = 1'b1;
        end
      end
      if (d_in_valid && o_in_ready) sb_q.push_back(model(d_instr, d_pc));
    end
    if (d_wb_en && d_wb_addr != 5'd0) ref_rf[d_wb_addr] = d_wb_data;
  endtask

  task automatic test_reset();
    int nx;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_state out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      d_wb_en = 1'b1; d_wb_addr = 5'(i); d_wb_data = 32'hA5A5_0000 | 32'(i);
      tick();
    end
    idle();
    d_in_valid = 1'b1; d_instr = rtype(5'd1, 5'd2, 5'd3); d_out_ready = 1'b0;
    tick();
    d_in_valid = 1'b0;
    tick();
    n_chk++;
    if (o_out_valid !== 1'b1) $display("FAIL reset_prefill out_valid=%b want 1", o_out_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_async out_valid=%b out_instr=%h in_ready=%b want 0/0/1",
               bus.out_valid, bus.out_instr, bus.in_ready);
    else n_pass++;
    sb_q.delete();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nx = 1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      d_in_valid = (nx <= 31);
      d_instr    = rtype(nx[4:0], nx[4:0], 5'd0);
      d_pc       = 32'h100 + 32'(nx * 4);
      tick();
      if (d_in_valid && o_in_ready) nx++;
      if (popped) begin
        n_chk++;
        if (o_out !== exp_out) $display("FAIL reset_rf_read got %h want %h", o_out, exp_out);
        else n_pass++;
        n_chk++;
        if ((o_out.rs_data | o_out.rt_data) !== 32'h0)
          $display("FAIL reset_rf_zero instr=%h rs=%h rt=%h want 0", o_out.instr, o_out.rs_data, o_out.rt_data);
        else n_pass++;
      end
      if (unexpected) begin n_chk++; $display("FAIL reset_spurious got %h want none", o_out); end
      if (nx > 31 && sb_q.size() == 0) break;
    end
    idle();
    n_chk++;
    if (sb_q.size() != 0 || nx <= 31) $display("FAIL reset_drain left=%0d next=%0d want 0/32", sb_q.size(), nx);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [31:0] ins [3];
    logic        we  [3];
    logic [4:0]  wa  [3];
    logic [31:0] wd  [3];
    int nx, pi;
    ins = '{rtype(5'd5, 5'd0, 5'd3), rtype(5'd0, 5'd5, 5'd4), rtype(5'd0, 5'd0, 5'd6)};
    we  = '{1'b1, 1'b1, 1'b0};
    wa  = '{5'd5, 5'd0, 5'd0};
    wd  = '{32'h0000_1234, 32'hFFFF_FFFF, 32'h0};
    nx = 0; pi = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      d_in_valid = (nx < 3);
      d_instr    = (nx < 3) ? ins[nx] : 32'h0;
      d_wb_en    = (nx < 3) ? we[nx] : 1'b0;
      d_wb_addr  = (nx < 3) ? wa[nx] : 5'd0;
      d_wb_data  = (nx < 3) ? wd[nx] : 32'h0;
      d_pc       = 32'h200 + 32'(nx * 4);
      tick();
      if (d_in_valid && o_in_ready) nx++;
      if (popped) begin
        n_chk++;
        if (o_out !== exp_out) $display("FAIL bypass_out got %h want %h", o_out, exp_out);
        else n_pass++;
        n_chk++;
        if ((pi == 0 && o_out.rs_data !== 32'h1234) ||
            (pi == 1 && (o_out.rs_data !== 32'h0 || o_out.rt_data !== 32'h1234)) ||
            (pi == 2 && o_out.rs_data !== 32'h0))
          $display("FAIL bypass_value idx=%0d rs=%h rt=%h", pi, o_out.rs_data, o_out.rt_data);
        else n_pass++;
        pi++;
      end
      if (unexpected) begin n_chk++; $display("FAIL bypass_spurious got %h want none", o_out); end
      if (nx >= 3 && sb_q.size() == 0) break;
    end
    idle();
    n_chk++;
    if (pi != 3) $display("FAIL bypass_count got %0d want 3", pi);
    else n_pass++;
  endtask

  task automatic test_imm_dst();
    logic [31:0] ins  [5];
    logic [31:0] eimm [5];
    int nx, pi;
    ins  = '{itype(6'h08, 5'd1, 5'd2, 16'h8000), itype(6'h0D, 5'd1, 5'd2, 16'h8000),
             itype(6'h0F, 5'd0, 5'd3, 16'h8000), {6'h03, 26'h000_0040},
             itype(6'h0E, 5'd2, 5'd4, 16'h8000)};
    eimm = '{32'hFFFF_8000, 32'h0000_8000, 32'h8000_0000, 32'h0000_0040, 32'h0000_8000};
    nx = 0; pi = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      d_in_valid = (nx < 5);
      d_instr    = (nx < 5) ? ins[nx] : 32'h0;
      d_pc       = 32'h300 + 32'(nx * 4);
      tick();
      if (d_in_valid) begin
        n_chk++;
        if (o_in_ready !== 1'b1) $display("FAIL imm_throughput in_ready=%b want 1", o_in_ready);
        else n_pass++;
      end
      if (d_in_valid && o_in_ready) nx++;
      if (popped) begin
        n_chk++;
        if (o_out !== exp_out) $display("FAIL imm_out got %h want %h", o_out, exp_out);
        else n_pass++;
        n_chk++;
        if (o_out.imm !== eimm[pi]) $display("FAIL imm_value idx=%0d got %h want %h", pi, o_out.imm, eimm[pi]);
        else n_pass++;
        if (pi == 3) begin
          n_chk++;
          if (o_out.dst !== 5'd31) $display("FAIL jal_dst got %0d want 31", o_out.dst);
          else n_pass++;
        end
        pi++;
      end
      if (unexpected) begin n_chk++; $display("FAIL imm_spurious got %h want none", o_out); end
      if (nx >= 5 && sb_q.size() == 0) break;
    end
    idle();
    n_chk++;
    if (pi != 5) $display("FAIL imm_count got %0d want 5", pi);
    else n_pass++;
  endtask

  task automatic test_hazard();
    logic [31:0] lw_i, add_i, ind_i;
    logic [31:0] t_ins [9];
    logic        t_iv  [9];
    logic        t_or  [9];
    logic        t_fl  [9];
    logic        e_rdy [9];
    logic        e_ov  [9];
    int pi;
    lw_i  = itype(6'h23, 5'd1, 5'd8, 16'h0004);
    add_i = rtype(5'd8, 5'd2, 5'd9);
    ind_i = rtype(5'd3, 5'd4, 5'd10);
    d_wb_en = 1'b1; d_wb_addr = 5'd8; d_wb_data = 32'h88; tick();
    d_wb_addr = 5'd2; d_wb_data = 32'h22; tick();
    idle();
    t_ins = '{lw_i, add_i, add_i, lw_i, ind_i, lw_i, add_i, 32'h0, 32'h0};
    t_iv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t_or  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    t_fl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e_rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e_ov  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pi = 0;
    for (int c = 0; c < 9; c++) begin
      d_in_valid = t_iv[c]; d_instr = t_ins[c]; d_out_ready = t_or[c]; d_flush = t_fl[c];
      d_pc = 32'h400 + 32'(c * 4);
      tick();
      n_chk++;
      if (o_in_ready !== e_rdy[c] || o_out_valid !== e_ov[c])
        $display("FAIL hazard_cycle%0d in_ready=%b out_valid=%b want %b/%b", c, o_in_ready, o_out_valid,
                 e_rdy[c], e_ov[c]);
      else n_pass++;
      if (popped) begin
        n_chk++;
        if (o_out !== exp_out) $display("FAIL hazard_out got %h want %h", o_out, exp_out);
        else n_pass++;
        if (pi == 1) begin
          n_chk++;
          if (o_out.rs_data !== 32'h88 || o_out.rt_data !== 32'h22 || o_out.dst !== 5'd9)
            $display("FAIL hazard_dep rs=%h rt=%h dst=%0d want 88/22/9", o_out.rs_data, o_out.rt_data, o_out.dst);
          else n_pass++;
        end
        pi++;
      end
      if (unexpected) begin n_chk++; $display("FAIL hazard_spurious got %h want none", o_out); end
    end
    idle();
    n_chk++;
    if (pi != 4 || sb_q.size() != 0) $display("FAIL hazard_count got %0d left %0d want 4/0", pi, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure_flush();
    logic [31:0] t_ins [9];
    logic        t_iv  [9];
    logic        t_or  [9];
    logic        t_fl  [9];
    logic        e_rdy [9];
    logic        e_ov  [9];
    int pi;
    t_ins = '{rtype(5'd1, 5'd2, 5'd3), rtype(5'd4, 5'd5, 5'd6), rtype(5'd4, 5'd5, 5'd6),
              rtype(5'd4, 5'd5, 5'd6), rtype(5'd4, 5'd5, 5'd6), 32'h0,
              itype(6'h08, 5'd7, 5'd8, 16'h0010), 32'h0, 32'h0};
    t_iv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    t_or  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_fl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e_ov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    pi = 0;
    for (int c = 0; c < 9; c++) begin
      d_in_valid = t_iv[c]; d_instr = t_ins[c]; d_out_ready = t_or[c]; d_flush = t_fl[c];
      d_pc = 32'h500 + 32'(c * 4);
      tick();
      n_chk++;
      if (o_in_ready !== e_rdy[c] || o_out_valid !== e_ov[c])
        $display("FAIL bp_cycle%0d in_ready=%b out_valid=%b want %b/%b", c, o_in_ready, o_out_valid,
                 e_rdy[c], e_ov[c]);
      else n_pass++;
      if (c >= 1 && c <= 3) begin
        n_chk++;
        if (sb_q.size() != 1 || o_out !== sb_q[0]) $display("FAIL bp_hold got %h queued=%0d", o_out, sb_q.size());
        else n_pass++;
      end
      if (popped) begin
        n_chk++;
        if (o_out !== exp_out) $display("FAIL bp_out got %h want %h", o_out, exp_out);
        else n_pass++;
        pi++;
      end
      if (unexpected) begin n_chk++; $display("FAIL bp_flushed_presented got %h want none", o_out); end
    end
    idle();
    n_chk++;
    if (pi != 1 || sb_q.size() != 0) $display("FAIL bp_count got %0d left %0d want 1/0", pi, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    idle();
    apply();
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_bypass();
    test_imm_dst();
    test_hazard();
    test_backpressure_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/idecode_pipe.md
# idecode_pipe

Parametrised pipelined instruction-decode stage for the minisys CPU: a register file with a write-back bypass, destination-register selection, a mode-aware immediate extender, and a registered ID/EX output stage with a valid/ready handshake. It adds several behaviours to the single-cycle decoder:
- load-use hazard detection with bubble insertion
- downstream back-pressure
- pipeline flush

It sits between the fetch stage (instruction source) and the execute stage, and receives write-back from the MEM/WB stage.

## Interface
- DATA_W, 32, datapath width; must be ≥ 32.
- REG_AW, 5, register-address width; the file holds 2^REG_AW registers.
- LINK_REG, 31, destination register for jal.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction/pc_plus4 valid from fetch.
- in_ready  out  1  stage accepts the input this cycle.
- instruction  in  32  MIPS instruction.
- pc_plus4  in  DATA_W  PC+4 of the instruction.
- wb_en  in  1  write-back enable.
- wb_addr  in  REG_AW  write-back register.
- wb_data  in  DATA_W  write-back data.
- flush  in  1  kill the output stage and the current input.
- out_valid  out  1  ID/EX register holds a live instruction.
- out_ready  in  1  execute stage consumes the output this cycle.
- out_rs_data, out_rt_data  out  DATA_W  operand values.
- out_imm  out  DATA_W  extended immediate.
- out_dst  out  REG_AW  destination register.
- out_pc_plus4  out  DATA_W  forwarded PC+4.
- out_instr  out  32  forwarded instruction.

## Operation
- **Register file**
  - Written on the rising edge when wb_en=1 and wb_addr≠0.
  - Register 0 always reads 0.
  - Reads are combinational from rs=instruction[25:21] and rt=instruction[20:16].
- **Bypass:** if wb_en=1, wb_addr≠0 and wb_addr equals the read address, the read returns wb_data in the same cycle (write-before-read).
- **Destination select**
  - opcode 0x00 (R-type): rd=instruction[15:11].
  - opcode 0x03 (jal): LINK_REG.
  - All other opcodes: rt.
- **Immediate extension of imm=instruction[15:0]**
  - andi/ori/xori (0x0C/0x0D/0x0E): zero-extend.
  - lui (0x0F): {imm,16'h0}, sign-extended to DATA_W.
  - All other opcodes: sign-extend from imm[15].
- **Load-use hazard**
  - Condition: hazard = out_valid, out_instr opcode is lw (0x23), out_dst≠0, and (rs==out_dst or rt==out_dst).
  - The rt comparison is always made, so detection is conservative.
  - During a hazard, in_ready=0.
- **Ready:** in_ready = (!out_valid | out_ready) & !hazard, or 1 while flush=1.
- **Output register update, in priority order**
  1. flush=1: out_valid←0; the input is discarded.
  2. in_valid & in_ready: capture all decoded fields; out_valid←1.
  3. out_ready=1 (including hazard cycles): out_valid←0, which inserts the bubble.
  4. Otherwise: hold every field.
- **Captured operand values**
  - Operands are sampled only at capture and are not refreshed while held.
  - Forwarding from EX/MEM is the execute stage's responsibility.

## Timing
- Reset (reset=0, asynchronous): all registers ←0 and all output-stage fields ←0, so out_valid=0. in_ready=1 after reset.
- Latency is 1 cycle from the in_valid&in_ready edge to out_valid=1 with the decoded fields.
- Throughput is one instruction per cycle when out_ready=1 and there is no hazard.
- A load-use hazard costs exactly one bubble cycle:
  - The lw leaves on the next out_ready edge, which clears the hazard.
  - The dependent instruction is captured on the following edge.
- Simultaneous wb write and read of the same register: the bypassed new value is captured.
- Simultaneous flush and hazard: flush wins; out_valid=0 next cycle.
- Reset deasserted mid-stream: the first edge after release behaves as from an empty stage.

## Test plan
- Reset with the register file pre-written, then release and read r1..r31 → all 0; out_valid=0; in_ready=1.
- wb_en=1, wb_addr=5, wb_data=0x1234 while the input add reads rs=5 → out_rs_data=0x1234 on the next edge. A write to r0 of 0xFFFF_FFFF → r0 still reads 0.
- Immediate 0x8000 with addi, ori and lui:
  - addi → out_imm=0xFFFF_8000.
  - ori → 0x0000_8000.
  - lui → 0x8000_0000.
- jal with DATA_W=32 → out_dst=31.
- lw r8 followed by add r9,r8,r2 with out_ready=1:
  - in_ready=0 for one cycle, then one out_valid=0 bubble.
  - The add appears the next cycle with the correct fields.
  - An independent follower shows no bubble.
- out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0. Assert flush → out_valid=0 next edge, and the held and incoming instructions are never presented.
